ifetch_unit: RTL and testbench
==============================

// Module: ifetch_unit
// PURPOSE
//  Instruction fetch stage directly upstream of the IF/ID pipeline register.
//  - Owns the fetch PC and issues 32-bit fetch requests to instruction memory over a req/gnt + rvalid handshake.
//  - Buffers returned instructions with their PCs in a small queue and presents the queue head to IF/ID.
//  - Discards stale responses after a branch/jump redirect.
// PARAMETERS
//  QDEPTH    2            fetch queue entries, power of 2, >=2
//  RESET_PC  `PMEM_START  fetch PC after reset
// PORTS
//  clock          in   1   clock
//  reset          in   1   synchronous, active-high reset
//  stall_i        in   1   IF/ID not accepting; head instruction is held
//  redirect_i     in   1   control-flow redirect from EX (same pulse as IF/ID flush)
//  redirect_pc_i  in   64  redirect target
//  imem_req_o     out  1   fetch request valid
//  imem_addr_o    out  64  fetch address, word aligned
//  imem_gnt_i     in   1   request accepted this cycle
//  imem_rvalid_i  in   1   response valid (in order, at most one outstanding)
//  imem_rdata_i   in   32  response instruction
//  inst_o         out  32  instruction to IF/ID; `NOP when valid_o=0
//  pc_o           out  64  PC of inst_o; fetch PC when valid_o=0
//  valid_o        out  1   queue head valid
// BEHAVIOUR
//  - Reset values:
//    - fetch_pc=RESET_PC, queue empty, state REQ, discard=0.
//    - imem_req_o=0 in the reset cycle; valid_o=0; inst_o=`NOP; pc_o=RESET_PC.
//  - FSM REQ: imem_req_o = (count<QDEPTH); imem_addr_o=fetch_pc.
//    - req/addr stay stable until gnt.
//    - Transition: gnt -> RESP, fetch_pc += 4 (mod 2^64), tag=addr.
//  - FSM RESP: imem_req_o=0.
//    - On rvalid: push {rdata, tag} unless discard; clear discard; -> REQ.
//  - Max one outstanding request. Issue only when count<QDEPTH, so a push never overflows.
//  - Dequeue: pop when valid_o & ~stall_i. Push and pop in the same cycle are allowed, count unchanged.
//    - Output is combinational from the queue head; load-to-output latency is 1 cycle after rvalid.
//  - Redirect (priority over stall, push, pop):
//    - Next cycle: queue empty, valid_o=0, fetch_pc = {redirect_pc_i[63:2],2'b00}.
//    - State REQ, not yet granted: the request stays stable; fetch_pc takes the new target.
//      - On gnt: fetch_pc is not incremented; go to RESP with discard=1.
//    - State REQ with gnt in the same cycle: -> RESP with discard=1.
//    - State RESP, no rvalid this cycle: discard=1.
//    - State RESP with rvalid in the same cycle: response dropped; -> REQ.
//    - Back-to-back redirects: the last one wins.
//  - Reset mid-RESP: state returns to REQ; the in-flight response arriving after reset is dropped via discard=1.
//    - Memory must not drive rvalid later than reset+1 otherwise.
//  - Low 2 bits of redirect_pc_i are ignored; no misalign trap.
// CONFIGURATION
//  IFU_PERF_EN defined:
//    - Adds outputs perf_fetched_o[63:0]: count of instructions popped.
//    - Adds perf_starve_o[63:0]: count of cycles with valid_o=0 & ~stall_i.
//    - Both are 0 at reset and wrap mod 2^64.
//  IFU_PERF_EN undefined: the ports and counters are absent; behaviour is otherwise identical.
// STRUCTURE
//  - define.v: `NOP, `PMEM_START, plus new `IFU_ST_REQ/`IFU_ST_RESP state encodings.
//  - Sub-module ifu_queue: parameterised sync FIFO.
//    - Interface: push/pop/flush, full/empty, count.
//    - Entry is {pc[63:0], inst[31:0]}.
//  - FSM, PC and discard logic live in ifetch_unit.
// TESTING
//  - Reset, zero-wait memory (gnt=1, rvalid next cycle):
//    - First imem_addr_o=0x80000000.
//    - valid_o pcs are 0x80000000, 0x80000004, 0x80000008, in order.
//  - stall_i=1 held, QDEPTH=2: exactly 2 entries are queued, then imem_req_o=0.
//    - Releasing the stall pops 1 per cycle, head pc stays in order.
//  - redirect_i in RESP, redirect_pc_i=0x80000103:
//    - Stale rdata is dropped.
//    - Next granted addr=0x80000100; first valid pc_o=0x80000100.
//  - redirect_i in the same cycle as rvalid: that instruction never appears, and the queue is empty the next cycle.
//  - gnt held low 5 cycles with a redirect at cycle 2: addr stays stable until gnt, then the redirect target is fetched.
//  - reset pulsed in RESP with rvalid arriving in the following cycle: response ignored, first output pc=0x80000000.

Source files
------------

// File: rtl/ifetch_unit_pkg.sv
// Shared constants, state encoding and fetch-queue entry type for the instruction fetch unit.
package ifetch_unit_pkg;

  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam logic [63:0] PMEM_START = 64'h0000_0000_8000_0000;

  typedef enum logic {
    IFU_ST_REQ  = 1'b0,
    IFU_ST_RESP = 1'b1
  } ifu_state_e;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } ifu_entry_t;

  // Redirect targets are forced onto a word boundary; low bits are dropped silently.
  function automatic logic [63:0] align_pc(input logic [63:0] pc);
    return {pc[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_unit_queue.sv
// Synchronous FIFO holding fetched {pc, inst} pairs; flush empties it on the next edge.
module ifu_queue
  import ifetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  ifu_entry_t             push_data,
  output ifu_entry_t             head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  ifu_entry_t      mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; occupancy alone decides what is visible.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the fetch PC, talks req/gnt/rvalid to imem, queues responses for IF/ID.
// Optional IFU_PERF_EN adds popped-instruction and starvation counters.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter int unsigned QDEPTH   = 2,
  parameter logic [63:0] RESET_PC = PMEM_START
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [63:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [63:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] inst_o,
  output logic [63:0] pc_o,
  output logic        valid_o
`ifdef IFU_PERF_EN
  ,
  output logic [63:0] perf_fetched_o,
  output logic [63:0] perf_starve_o
`endif
);

  localparam int unsigned CW = $clog2(QDEPTH) + 1;

  ifu_state_e    state;
  ifu_state_e    state_n;
  logic [63:0]   fetch_pc;
  logic [63:0]   tag_pc;
  logic [63:0]   held_addr;
  logic [63:0]   target_pc;
  logic          discard;
  logic          stale;
  logic          granted;
  logic          has_room;
  logic [CW-1:0] q_count;
  logic          q_empty;
  logic          q_full_unused;
  logic          q_push;
  logic          q_pop;
  ifu_entry_t    q_head;
  ifu_entry_t    q_wdata;
  logic          unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc_i[1:0];
  assign target_pc      = align_pc(redirect_pc_i);
  assign has_room       = (q_count < CW'(QDEPTH));
  assign granted        = imem_req_o & imem_gnt_i;

  always_ff @(posedge clock) begin
    if (reset) state <= IFU_ST_REQ;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IFU_ST_REQ:  if (granted)       state_n = IFU_ST_RESP;
      IFU_ST_RESP: if (imem_rvalid_i) state_n = IFU_ST_REQ;
      default:                        state_n = IFU_ST_REQ;
    endcase
  end

  // A request redirected before its grant keeps its original address until accepted.
  always_comb begin
    imem_req_o  = 1'b0;
    imem_addr_o = stale ? held_addr : fetch_pc;
    if (!reset && state == IFU_ST_REQ) imem_req_o = has_room | stale;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc  <= RESET_PC;
      tag_pc    <= RESET_PC;
      held_addr <= RESET_PC;
      stale     <= 1'b0;
      // Reset while a response is in flight: mark it so it cannot land in the queue.
      discard   <= (state == IFU_ST_RESP) & ~imem_rvalid_i;
    end else if (state == IFU_ST_REQ) begin
      if (granted) begin
        tag_pc  <= imem_addr_o;
        stale   <= 1'b0;
        discard <= redirect_i | stale | (discard & ~imem_rvalid_i);
        if (redirect_i)  fetch_pc <= target_pc;
        else if (!stale) fetch_pc <= fetch_pc + 64'd4;
      end else begin
        if (imem_rvalid_i) discard <= 1'b0;
        if (redirect_i) begin
          fetch_pc <= target_pc;
          if (imem_req_o) begin
            stale     <= 1'b1;
            held_addr <= imem_addr_o;
          end
        end
      end
    end else begin
      if (imem_rvalid_i)   discard <= 1'b0;
      else if (redirect_i) discard <= 1'b1;
      if (redirect_i) fetch_pc <= target_pc;
    end
  end

  assign q_wdata = '{pc: tag_pc, inst: imem_rdata_i};
  assign q_push  = ~reset & ~redirect_i & (state == IFU_ST_RESP) & imem_rvalid_i & ~discard;
  assign q_pop   = valid_o & ~stall_i & ~redirect_i;

  ifu_queue #(.DEPTH(QDEPTH)) u_queue (
    .clock     (clock),
    .reset     (reset),
    .push      (q_push),
    .pop       (q_pop),
    .flush     (redirect_i),
    .push_data (q_wdata),
    .head      (q_head),
    .full      (q_full_unused),
    .empty     (q_empty),
    .count     (q_count)
  );

  assign valid_o = ~reset & ~q_empty;
  assign inst_o  = valid_o ? q_head.inst : NOP;
  assign pc_o    = valid_o ? q_head.pc : (reset ? RESET_PC : fetch_pc);

`ifdef IFU_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_fetched_o <= '0;
      perf_starve_o  <= '0;
    end else begin
      if (q_pop)                perf_fetched_o <= perf_fetched_o + 64'd1;
      if (!valid_o && !stall_i) perf_starve_o  <= perf_starve_o + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed vector table, corner-case sequences, randomized run vs program-order model.
module tb_ifetch_unit;

  localparam logic [31:0] NOP_I = 32'h0000_0013;
  localparam logic [63:0] BOOT  = 64'h0000_0000_8000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [63:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [63:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic [31:0] inst_o;
  logic [63:0] pc_o;
  logic        valid_o;
`ifdef IFU_PERF_EN
  logic [63:0] perf_fetched;
  logic [63:0] perf_starve;
`endif

  always #5 clock = ~clock;

  ifetch_unit #(.QDEPTH(2)) dut (
    .clock         (clock),
    .reset         (reset),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .inst_o        (inst_o),
    .pc_o          (pc_o),
    .valid_o       (valid_o)
`ifdef IFU_PERF_EN
    ,
    .perf_fetched_o(perf_fetched),
    .perf_starve_o (perf_starve)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_pops  = 0;

  // Memory model: grant policy, latency and the single outstanding response.
  int          gnt_mode  = 0;   // 0 always, 1 random 70%, 2 never
  int          fixed_lat = 1;
  bit          rand_lat  = 1'b0;
  logic        pend      = 1'b0;
  int          pend_cnt  = 0;
  logic [63:0] pend_addr = '0;

  logic        prev_wait = 1'b0;
  logic [63:0] prev_addr = '0;
  logic [63:0] exp_pc    = BOOT;

  logic        s_req, s_valid, s_granted;
  logic [63:0] s_addr, s_pc;
  logic [31:0] s_inst;

  typedef struct packed {
    logic        rst;
    logic        stl;
    logic        rd;
    logic [63:0] rpc;
    logic        e_req;
    logic [63:0] e_addr;
    logic        e_valid;
    logic [63:0] e_pc;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_0001;
  endfunction

  function automatic vec_t mk(input logic rst, input logic stl, input logic rd, input logic [63:0] rpc,
                              input logic e_req, input logic [63:0] e_addr,
                              input logic e_valid, input logic [63:0] e_pc);
    vec_t v;
    v.rst = rst; v.stl = stl; v.rd = rd; v.rpc = rpc;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // One clock: drive inputs after the edge, sample before the next, run memory and scoreboard.
  task automatic cycle(input logic rst, input logic stl, input logic rd, input logic [63:0] rpc);
    @(posedge clock);
    #1;
    reset = rst; stall_i = stl; redirect_i = rd; redirect_pc_i = rpc;
    if (pend) pend_cnt--;
    imem_rvalid_i = pend && (pend_cnt == 0);
    imem_rdata_i  = imem_rvalid_i ? inst_of(pend_addr) : 32'hDEAD_BEEF;
    #1;
    case (gnt_mode)
      0:       imem_gnt_i = 1'b1;
      1:       imem_gnt_i = ($urandom_range(0, 9) < 7);
      default: imem_gnt_i = 1'b0;
    endcase
    #2;
    s_req = imem_req_o; s_addr = imem_addr_o; s_valid = valid_o;
    s_pc = pc_o; s_inst = inst_o;
    s_granted = imem_req_o && imem_gnt_i;

    if (prev_wait && !rst) begin
      chk1("req_held", imem_req_o, 1'b1);
      chk64("addr_held", imem_addr_o, prev_addr);
    end
    if (imem_req_o) chk64("addr_align", {62'd0, imem_addr_o[1:0]}, 64'd0);
    if (imem_req_o && pend) chk1("one_outstanding", imem_rvalid_i, 1'b1);
    prev_wait = imem_req_o && !imem_gnt_i && !rst;
    prev_addr = imem_addr_o;

    // Program-order model: sequential pcs from boot or the last redirect target.
    if (rst) exp_pc = BOOT;
    else if (rd) exp_pc = {rpc[63:2], 2'b00};
    else if (valid_o && !stl) begin
      chk64("pop_pc", pc_o, exp_pc);
      chk32("pop_inst", inst_o, inst_of(exp_pc));
      exp_pc = exp_pc + 64'd4;
      n_pops++;
    end
    if (!valid_o) chk32("idle_nop", inst_o, NOP_I);

    if (imem_rvalid_i) pend = 1'b0;
    if (s_granted) begin
      pend      = 1'b1;
      pend_cnt  = rand_lat ? int'($urandom_range(1, 3)) : fixed_lat;
      pend_addr = imem_addr_o;
    end
  endtask

  task automatic watch(input int budget, output logic got_g, output logic [63:0] g_addr,
                       output logic got_v, output logic [63:0] v_pc);
    got_g = 1'b0; got_v = 1'b0; g_addr = '0; v_pc = '0;
    for (int i = 0; i < budget && !got_v; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 64'd0);
      if (s_granted && !got_g) begin got_g = 1'b1; g_addr = s_addr; end
      if (s_valid) begin got_v = 1'b1; v_pc = s_pc; end
    end
  endtask

  // Withhold grants long enough for any in-flight response to return.
  task automatic quiesce();
    gnt_mode = 2;
    repeat (4) cycle(1'b0, 1'b1, 1'b0, 64'd0);
  endtask

  initial begin
    logic        got_g, got_v;
    logic [63:0] g_addr, v_pc;
    int          p0;

    // Zero-wait memory: streaming, stall fill/drain, redirect coinciding with rvalid.
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,                0, 64'h8000_0000));
    tbl.push_back(mk(0, 0, 0, 0, 1, 64'h8000_0000, 0, 64'h8000_0000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,                0, 64'h8000_0004));
    tbl.push_back(mk(0, 0, 0, 0, 1, 64'h8000_0004, 1, 64'h8000_0000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,                0, 64'h8000_0008));
    tbl.push_back(mk(0, 0, 0, 0, 1, 64'h8000_0008, 1, 64'h8000_0004));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,                0, 64'h8000_000C));
    tbl.push_back(mk(0, 1, 0, 0, 1, 64'h8000_000C, 1, 64'h8000_0008));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0,                1, 64'h8000_0008));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0,                1, 64'h8000_0008));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0,                1, 64'h8000_0008));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,                1, 64'h8000_0008));
    tbl.push_back(mk(0, 0, 0, 0, 1, 64'h8000_0010, 1, 64'h8000_000C));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,                0, 64'h8000_0014));
    tbl.push_back(mk(0, 1, 0, 0, 1, 64'h8000_0014, 1, 64'h8000_0010));
    tbl.push_back(mk(0, 0, 1, 64'h8000_0103, 0, 0,    1, 64'h8000_0010));
    tbl.push_back(mk(0, 0, 0, 0, 1, 64'h8000_0100, 0, 64'h8000_0100));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,                0, 64'h8000_0104));
    tbl.push_back(mk(0, 0, 0, 0, 1, 64'h8000_0104, 1, 64'h8000_0100));

    foreach (tbl[i]) begin
      cycle(tbl[i].rst, tbl[i].stl, tbl[i].rd, tbl[i].rpc);
      chk1($sformatf("vec%0d_req", i), s_req, tbl[i].e_req);
      if (tbl[i].e_req) chk64($sformatf("vec%0d_addr", i), s_addr, tbl[i].e_addr);
      chk1($sformatf("vec%0d_valid", i), s_valid, tbl[i].e_valid);
      chk64($sformatf("vec%0d_pc", i), s_pc, tbl[i].e_pc);
      chk32($sformatf("vec%0d_inst", i), s_inst, tbl[i].e_valid ? inst_of(tbl[i].e_pc) : NOP_I);
    end

    // Redirect while waiting for a slow response: stale data dropped, target fetched next.
    quiesce();
    gnt_mode = 0; fixed_lat = 3;
    cycle(1'b1, 1'b0, 1'b0, 64'd0);
    cycle(1'b0, 1'b0, 1'b0, 64'd0);
    chk1("resp_redir_grant0", s_granted, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 64'h8000_0103);
    chk1("resp_redir_noreq", s_req, 1'b0);
    fixed_lat = 1;
    watch(30, got_g, g_addr, got_v, v_pc);
    chk1("resp_redir_granted", got_g, 1'b1);
    chk64("resp_redir_gaddr", g_addr, 64'h8000_0100);
    chk1("resp_redir_valid", got_v, 1'b1);
    chk64("resp_redir_pc", v_pc, 64'h8000_0100);

    // Grant withheld 5 cycles with a redirect on the 2nd: address holds, then target fetched.
    quiesce();
    cycle(1'b1, 1'b0, 1'b0, 64'd0);
    for (int k = 1; k <= 5; k++) begin
      cycle(1'b0, 1'b0, k == 2, 64'h8000_0202);
      chk1($sformatf("gnt_low%0d_req", k), s_req, 1'b1);
      chk64($sformatf("gnt_low%0d_addr", k), s_addr, 64'h8000_0000);
    end
    gnt_mode = 0;
    cycle(1'b0, 1'b0, 1'b0, 64'd0);
    chk1("gnt_low_granted", s_granted, 1'b1);
    chk64("gnt_low_old_addr", s_addr, 64'h8000_0000);
    watch(30, got_g, g_addr, got_v, v_pc);
    chk64("gnt_low_target_addr", g_addr, 64'h8000_0200);
    chk1("gnt_low_valid", got_v, 1'b1);
    chk64("gnt_low_first_pc", v_pc, 64'h8000_0200);

    // Reset pulsed while a response from 0x90000000 is in flight.
    quiesce();
    gnt_mode = 0; fixed_lat = 1;
    cycle(1'b1, 1'b0, 1'b0, 64'd0);
    cycle(1'b0, 1'b0, 1'b1, 64'h9000_0000);
    cycle(1'b0, 1'b0, 1'b0, 64'd0);
    fixed_lat = 2;
    cycle(1'b0, 1'b0, 1'b0, 64'd0);
    chk64("rst_resp_pre_addr", s_addr, 64'h9000_0000);
    fixed_lat = 1;
    cycle(1'b1, 1'b0, 1'b0, 64'd0);
    chk1("rst_resp_req_low", s_req, 1'b0);
    chk64("rst_resp_pc", s_pc, 64'h8000_0000);
    watch(30, got_g, g_addr, got_v, v_pc);
    chk64("rst_resp_gaddr", g_addr, 64'h8000_0000);
    chk1("rst_resp_valid", got_v, 1'b1);
    chk64("rst_resp_first_pc", v_pc, 64'h8000_0000);

    // Randomized traffic: random grants, latency, stalls and redirects.
    quiesce();
    cycle(1'b1, 1'b0, 1'b0, 64'd0);
    gnt_mode = 1; rand_lat = 1'b1;
    p0 = n_pops;
    for (int i = 0; i < 3000; i++) begin
      logic        rd;
      logic        st;
      logic [63:0] tgt;
      rd  = ($urandom_range(0, 99) < 3);
      st  = ($urandom_range(0, 99) < 30);
      tgt = BOOT + 64'($urandom_range(0, 255)) * 64'd4 + 64'($urandom_range(0, 3));
      cycle(1'b0, st, rd, tgt);
    end
    chk1("rand_progress", (n_pops - p0) >= 200, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
